// File: rtl/calc_pkg.sv
// Shared opcodes, instruction field layout and FSM state type for the
// calculator instruction sequencer.
package calc_pkg;

  localparam int WORD_W   = 11;
  localparam int CTRL_LSB = 8;
  localparam int WE_LSB   = 6;
  localparam int RD_LSB   = 4;
  localparam int IMM_LSB  = 0;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_HALT = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  localparam logic [WORD_W-1:0] HALT_WORD = 11'h300;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Register k ORed with zero: leaves every calculator register unchanged.
  function automatic logic [WORD_W-1:0] nop_word(input logic [1:0] k);
    return {OP_OR, k, k, 4'h0};
  endfunction

endpackage

// File: rtl/calc_prog_mem.sv
// Program store: DEPTH x 11-bit words, synchronous write, asynchronous read,
// every word reset to HALT.
module calc_prog_mem
  import calc_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [10:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [10:0]       rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= HALT_WORD;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/calc_sequencer.sv
// Issues one stored instruction per clock to the calculator until HALT or end
// of memory, then captures the selected calculator register as the result.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [10:0]       load_data,
  input  logic              start,
  input  logic [3:0]        rd_data_in,
  output logic [1:0]        calc_rd_addr,
  output logic [3:0]        calc_immediate,
  output logic [1:0]        calc_we_addr,
  output logic [2:0]        calc_control,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        result,
  output logic [1:0]        dbg_state
);

  // Handshake: no valid/ready pair; start and load_en are single-cycle
  // requests sampled on posedge, honoured only while busy is low.

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        result_q, result_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic [1:0]        drain_k_q, drain_k_d;
  logic [WORD_W-1:0] fetch_word;
  logic              busy_w;
  logic              mem_we;

  assign busy_w = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign mem_we = load_en && !busy_w;

  calc_prog_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_q),
    .rdata (fetch_word)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    result_d  = result_q;
    out_d     = out_q;
    drain_k_d = drain_k_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN: begin
        if (fetch_word[CTRL_LSB +: 3] == OP_HALT) begin
          drain_k_d = fetch_word[RD_LSB +: 2];
          out_d     = nop_word(fetch_word[RD_LSB +: 2]);
          state_d   = ST_DRAIN;
        end else begin
          out_d = fetch_word;
          // Last word issued: pc stays put and the drain reads its destination.
          if (pc_q == ADDR_W'(DEPTH - 1)) begin
            drain_k_d = fetch_word[WE_LSB +: 2];
            state_d   = ST_DRAIN;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        result_d = rd_data_in;
        out_d    = nop_word(drain_k_q);
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      result_q  <= '0;
      out_q     <= nop_word(2'd0);
      drain_k_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      result_q  <= result_d;
      out_q     <= out_d;
      drain_k_q <= drain_k_d;
    end
  end

  assign calc_control   = out_q[CTRL_LSB +: 3];
  assign calc_we_addr   = out_q[WE_LSB +: 2];
  assign calc_rd_addr   = out_q[RD_LSB +: 2];
  assign calc_immediate = out_q[IMM_LSB +: 4];
  assign busy           = busy_w;
  assign done           = (state_q == ST_DONE);
  assign pc             = pc_q;
  assign result         = result_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench: calc_sequencer driving a small behavioural calculator
// (four 4-bit registers written on every negedge).
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [10:0] load_data;
  logic        start;
  logic [3:0]  rd_data_in;
  logic [1:0]  calc_rd_addr;
  logic [3:0]  calc_immediate;
  logic [1:0]  calc_we_addr;
  logic [2:0]  calc_control;
  logic        busy;
  logic        done;
  logic [3:0]  pc;
  logic [3:0]  result;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int issue_cnt = 0;

  logic [3:0] regs [4] = '{4'h0, 4'h0, 4'h0, 4'h0};

  always #5 clk = ~clk;

  calc_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .start          (start),
    .rd_data_in     (rd_data_in),
    .calc_rd_addr   (calc_rd_addr),
    .calc_immediate (calc_immediate),
    .calc_we_addr   (calc_we_addr),
    .calc_control   (calc_control),
    .busy           (busy),
    .done           (done),
    .pc             (pc),
    .result         (result),
    .dbg_state      (dbg_state)
  );

  function automatic logic [3:0] alu(input logic [2:0] op, input logic [3:0] a,
                                     input logic [3:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a & ~b;
      3'b101:  return a | ~b;
      3'b110:  return a - b;
      3'b111:  return {3'b000, (a < b)};
      default: return a;
    endcase
  endfunction

  assign rd_data_in = regs[calc_rd_addr];

  always @(negedge clk) begin
    regs[calc_we_addr] <= alu(calc_control, regs[calc_rd_addr], calc_immediate);
    if (calc_control == 3'b010) issue_cnt = issue_cnt + 1;
  end

  function automatic logic [10:0] w(input logic [2:0] ctrl, input logic [1:0] we,
                                    input logic [1:0] rd, input logic [3:0] imm);
    return {ctrl, we, rd, imm};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] addr, input logic [10:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    step();
    load_en   = 1'b0;
  endtask

  task automatic check_nop(input string tag, input logic [1:0] k);
    check({tag, "_ctrl"}, 16'(calc_control), 16'h1);
    check({tag, "_rd"}, 16'(calc_rd_addr), 16'(k));
    check({tag, "_we"}, 16'(calc_we_addr), 16'(k));
    check({tag, "_imm"}, 16'(calc_immediate), 16'h0);
  endtask

  initial begin
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
    step(); step();

    // Reset state
    check_nop("rst", 2'd0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    check("rst_result", 16'(result), 16'h0);
    check("rst_pc", 16'(pc), 16'h0);
    check("rst_state", 16'(dbg_state), 16'h0);
    rst_n = 1'b1;
    step();

    // r0 = 0+5 = 5, r1 = 5+3 = 8, HALT reads r1
    load(4'd0, w(3'b010, 2'd0, 2'd0, 4'd5));
    load(4'd1, w(3'b010, 2'd1, 2'd0, 4'd3));
    load(4'd2, w(3'b011, 2'd0, 2'd1, 4'd0));
    start = 1'b1; step(); start = 1'b0;
    check("t2_busy0", 16'(busy), 16'h1);
    check("t2_state_run", 16'(dbg_state), 16'h1);
    // start and a load of HALT into word 0 while busy: both dropped
    start = 1'b1; load_en = 1'b1; load_addr = 4'd0; load_data = 11'h300;
    step();
    start = 1'b0; load_en = 1'b0;
    check("t2_i0_ctrl", 16'(calc_control), 16'h2);
    check("t2_i0_imm", 16'(calc_immediate), 16'h5);
    check("t2_busy1", 16'(busy), 16'h1);
    step();
    check("t2_i1_we", 16'(calc_we_addr), 16'h1);
    check("t2_i1_imm", 16'(calc_immediate), 16'h3);
    check("t2_busy2", 16'(busy), 16'h1);
    step();
    check_nop("t2_halt", 2'd1);
    check("t2_busy3", 16'(busy), 16'h1);
    check("t2_done3", 16'(done), 16'h0);
    step();
    check("t2_busy4", 16'(busy), 16'h0);
    check("t2_done", 16'(done), 16'h1);
    check("t2_result", 16'(result), 16'h8);
    check("t2_pc", 16'(pc), 16'h2);

    // Rerun with word 0 intact: r0 = 5+5 = 10, r1 = 10+3 = 13
    start = 1'b1; step(); start = 1'b0;
    check("t5_done_clr", 16'(done), 16'h0);
    step();
    check("t5_i0_ctrl", 16'(calc_control), 16'h2);
    check("t5_i0_imm", 16'(calc_immediate), 16'h5);
    step(); step(); step();
    check("t5_done", 16'(done), 16'h1);
    check("t5_result", 16'(result), 16'hD);

    // Clear r0 and r2 ahead of the wrap and full-memory runs
    load(4'd0, w(3'b000, 2'd0, 2'd0, 4'd0));
    load(4'd1, w(3'b000, 2'd2, 2'd2, 4'd0));
    load(4'd2, w(3'b011, 2'd0, 2'd0, 4'd0));
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step(); step();
    check("clr_done", 16'(done), 16'h1);
    check("clr_result", 16'(result), 16'h0);

    // r2 = 0-1 wraps to F; word 0 written on the same edge as start
    load(4'd1, w(3'b011, 2'd0, 2'd2, 4'd0));
    load_en = 1'b1; load_addr = 4'd0; load_data = w(3'b110, 2'd2, 2'd2, 4'd1);
    start = 1'b1;
    step();
    load_en = 1'b0; start = 1'b0;
    step();
    check("t3_i0_ctrl", 16'(calc_control), 16'h6);
    check("t3_i0_we", 16'(calc_we_addr), 16'h2);
    step();
    check_nop("t3_halt", 2'd2);
    step();
    check("t3_done", 16'(done), 16'h1);
    check("t3_result", 16'(result), 16'hF);

    // Sixteen r0 += 1 with no HALT: 16 mod 16 = 0
    for (int i = 0; i < 16; i++) load(4'(i), w(3'b010, 2'd0, 2'd0, 4'd1));
    issue_cnt = 0;
    start = 1'b1; step(); start = 1'b0;
    repeat (16) step();
    check("t4_busy16", 16'(busy), 16'h1);
    check("t4_done16", 16'(done), 16'h0);
    check("t4_pc16", 16'(pc), 16'hF);
    step();
    check("t4_done", 16'(done), 16'h1);
    check("t4_result", 16'(result), 16'h0);
    check("t4_pc", 16'(pc), 16'hF);
    check("t4_issues", 16'(issue_cnt), 16'd16);
    check_nop("t4_drain", 2'd0);
    step(); step();
    check("t4_no_extra", 16'(issue_cnt), 16'd16);

    // Reset mid-run, then a run of the reset program (all HALT)
    start = 1'b1; step(); start = 1'b0;
    repeat (5) step();
    check("t6_busy", 16'(busy), 16'h1);
    rst_n = 1'b0;
    step();
    check_nop("t6_rst", 2'd0);
    check("t6_rst_busy", 16'(busy), 16'h0);
    check("t6_rst_pc", 16'(pc), 16'h0);
    check("t6_rst_state", 16'(dbg_state), 16'h0);
    rst_n = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
    check("t6_run_done", 16'(done), 16'h0);
    step();
    check("t6_drain_busy", 16'(busy), 16'h1);
    check_nop("t6_halt", 2'd0);
    step();
    check("t6_done", 16'(done), 16'h1);
    check("t6_pc", 16'(pc), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
